// File: rtl/sdram_resp.sv
// sdram_resp -- behavioural SDRAM device responder.
//
// Decodes SDRAM commands on the rising edge of clk and behaves like a small
// single-chip SDRAM. It tracks one open row per bank and supports LOAD MODE
// with burst lengths 1/2/4/8/full page and CAS latencies 2/3. Bursts use
// sequential column order. AUTO REFRESH events are counted.
// Memory is a 2^MEM_AW x 16 array indexed by {bank, row, column} truncated
// to MEM_AW bits; reset never touches its contents.
//
// Optional feature: define SDRAM_RESP_CHK_EN to build the protocol checker
// that drives the sticky proto_err flag; otherwise proto_err is tied low.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   sdram_cke          clock enable (low = all commands NOP, pipelines hold)
//   sdram_cs_n/ras_n/cas_n/we_n  command strobes
//   sdram_ban          bank address
//   sdram_addr         row / column / mode / A10 bus
//   sdram_dq           bidirectional data bus
//   mode_set           a LOAD MODE has been seen since reset
//   aref_cnt           saturating AUTO REFRESH count
//   proto_err          sticky protocol error (checker builds only)
module sdram_resp #(
  parameter int MEM_AW = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdram_cke,
  input  logic        sdram_cs_n,
  input  logic        sdram_ras_n,
  input  logic        sdram_cas_n,
  input  logic        sdram_we_n,
  input  logic [1:0]  sdram_ban,
  input  logic [12:0] sdram_addr,
  inout  wire  [15:0] sdram_dq,
  output logic        mode_set,
  output logic [15:0] aref_cnt,
  output logic        proto_err
);

  // {ras_n, cas_n, we_n} with cs_n low
  localparam logic [2:0] CMD_LMR = 3'b000;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_BST = 3'b110;

  logic [15:0]       mem [2**MEM_AW];
  logic [3:0]        open_q;
  logic [12:0]       row_q [4];
  logic [8:0]        bl_mask;     // burst length - 1
  logic              cl3;         // 1: CL=3, 0: CL=2
  logic              single_wr;
  logic              burst_act, burst_wr;
  logic [1:0]        burst_bank;
  logic [8:0]        burst_start, burst_idx;
  logic              vld_p0, vld_p1, dq_oe;
  logic [MEM_AW-1:0] rd_idx_p0, rd_idx_p1;
  logic [15:0]       dq_q;

  logic              cmd_en;
  logic [2:0]        cmd;
  logic              is_act, is_rd, is_wr, is_bst, is_pre, is_ref, is_lmr;
  logic              intr, cont, start, iss_rd, iss_wr;
  logic [1:0]        iss_bank;
  logic [8:0]        iss_col;
  logic [MEM_AW-1:0] iss_idx;
  logic              lmr_ok;
  logic [8:0]        lmr_mask;

  // Sequential burst order: the low bits wrap inside the BL-aligned block.
  function automatic logic [8:0] burst_col(input logic [8:0] base,
                                           input logic [8:0] idx,
                                           input logic [8:0] mask);
    return (base & ~mask) | ((base + idx) & mask);
  endfunction

  function automatic logic [MEM_AW-1:0] mem_index(input logic [1:0]  b,
                                                  input logic [12:0] r,
                                                  input logic [8:0]  c);
    logic [23:0] full;
    full = {b, r, c};
    return MEM_AW'(full);
  endfunction

  always_comb begin
    cmd_en = sdram_cke & ~sdram_cs_n;
    cmd    = {sdram_ras_n, sdram_cas_n, sdram_we_n};
    is_act = cmd_en & (cmd == CMD_ACT);
    is_rd  = cmd_en & (cmd == CMD_RD);
    is_wr  = cmd_en & (cmd == CMD_WR);
    is_bst = cmd_en & (cmd == CMD_BST);
    is_pre = cmd_en & (cmd == CMD_PRE);
    is_ref = cmd_en & (cmd == CMD_REF);
    is_lmr = cmd_en & (cmd == CMD_LMR);

    intr   = is_rd | is_wr | is_bst | is_pre;
    cont   = sdram_cke & burst_act & ~intr;
    start  = is_rd | is_wr;
    iss_rd = is_rd | (cont & ~burst_wr);
    iss_wr = is_wr | (cont & burst_wr);

    iss_bank = start ? sdram_ban : burst_bank;
    iss_col  = start ? sdram_addr[8:0] : burst_col(burst_start, burst_idx, bl_mask);
    iss_idx  = mem_index(iss_bank, row_q[iss_bank], iss_col);

    lmr_ok   = 1'b1;
    lmr_mask = 9'd0;
    case (sdram_addr[2:0])
      3'b000:  lmr_mask = 9'd0;
      3'b001:  lmr_mask = 9'd1;
      3'b010:  lmr_mask = 9'd3;
      3'b011:  lmr_mask = 9'd7;
      3'b111:  lmr_mask = 9'd511;
      default: lmr_ok   = 1'b0;
    endcase
    // CL codes 010 and 011 only; addr[4] then selects between them
    if (sdram_addr[6:5] != 2'b01) lmr_ok = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q      <= '0;
      for (int i = 0; i < 4; i++) row_q[i] <= '0;
      bl_mask     <= '0;
      cl3         <= 1'b1;
      single_wr   <= 1'b0;
      mode_set    <= 1'b0;
      aref_cnt    <= '0;
      burst_act   <= 1'b0;
      burst_wr    <= 1'b0;
      burst_bank  <= '0;
      burst_start <= '0;
      burst_idx   <= '0;
    end else begin
      if (is_act) begin
        open_q[sdram_ban] <= 1'b1;
        row_q[sdram_ban]  <= sdram_addr;
      end
      if (is_pre) begin
        if (sdram_addr[10]) open_q <= '0;
        else                open_q[sdram_ban] <= 1'b0;
      end
      if (is_lmr) begin
        mode_set <= 1'b1;
        if (lmr_ok) begin
          bl_mask   <= lmr_mask;
          cl3       <= sdram_addr[4];
          single_wr <= sdram_addr[9];
        end
      end
      if (is_ref && aref_cnt != 16'hFFFF) aref_cnt <= aref_cnt + 16'd1;

      // A new READ/WRITE restarts the burst; BST/PRECHARGE just end it.
      if (start) begin
        burst_wr    <= is_wr;
        burst_bank  <= sdram_ban;
        burst_start <= sdram_addr[8:0];
        burst_idx   <= 9'd1;
        burst_act   <= (bl_mask != 9'd0) && !(is_wr && single_wr);
      end else if (cont) begin
        burst_idx <= burst_idx + 9'd1;
        if (burst_idx == bl_mask) burst_act <= 1'b0;
      end else if (is_bst | is_pre) begin
        burst_act <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (iss_wr) mem[iss_idx] <= sdram_dq;
  end

  // Read pipeline: column issued at edge 0 lands in vld_p0; the output
  // register is loaded at edge CL-1 so the word is on the bus in cycle CL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      dq_oe  <= 1'b0;
    end else if (sdram_cke) begin
      vld_p0 <= iss_rd;
      vld_p1 <= vld_p0;
      dq_oe  <= cl3 ? vld_p1 : vld_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (sdram_cke) begin
      rd_idx_p0 <= iss_idx;
      rd_idx_p1 <= rd_idx_p0;
      dq_q      <= mem[cl3 ? rd_idx_p1 : rd_idx_p0];
    end
  end

  // A write-burst cycle owns the bus: read drive is dropped that cycle.
  assign sdram_dq = (dq_oe && !iss_wr) ? dq_q : 16'bz;

`ifdef SDRAM_RESP_CHK_EN
  logic chk_hit;
  logic unused_ok;

  always_comb begin
    chk_hit = ((is_rd | is_wr) & ~open_q[sdram_ban])
            | (is_act & open_q[sdram_ban])
            | ((is_lmr | is_ref) & (|open_q))
            | (is_lmr & ~lmr_ok)
            | (dq_oe & iss_wr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       proto_err <= 1'b0;
    else if (chk_hit) proto_err <= 1'b1;
  end

  // burst-type bit is ignored: bursts are always sequential
  assign unused_ok = &{1'b0, sdram_addr[3]};
`else
  logic unused_ok;

  assign proto_err = 1'b0;
  // open flags only feed the checker; burst-type bit is ignored
  assign unused_ok = &{1'b0, sdram_addr[3], open_q};
`endif

endmodule
